gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises one shared 2-input gate instance, such as and_gate, nand_gate or an or/xor build. It drives the gate's inA/inB through all four input vectors and waits a programmable settle time per vector. It samples the gate's outY and compares it against a parameterised truth table. It sits beside a gate under test in self-checking parts and reports pass/fail, a per-vector failure mask and an error count.

---
 rtl/gate_test_pkg.sv | 10 +
 rtl/sweep_timer.sv | 16 +
 rtl/gate_sweep_ctrl.sv | 83 ++++++++
 tb/tb_gate_sweep_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared types and truth tables for the 2-input gate sweeper
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} sweep_state_t;
  typedef logic [1:0] vec_idx_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: loadable 4-bit down-counter with zero flag
module sweep_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] loadVal,
  output logic [3:0] value,
  output logic       zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= 4'd0;
    else if (load) value <= loadVal;
    else if (dec) value <= value - 4'd1;
  assign zero = value == 4'd0;
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a 2-input gate through all vectors and checks outY
module gate_sweep_ctrl
  import gate_test_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_AND,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       drvA,
  output logic       drvB,
  input  logic       gateY,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  sweep_state_t state;
  vec_idx_t idx;
  logic [3:0] timerVal, newMask;
  logic timerZero, timerLoad, timerDec, miss;
  assign miss = gateY != EXPECT[idx];
  assign newMask = fail_mask | (miss ? 4'b0001 << idx : 4'b0000);
  assign timerLoad = (state == IDLE && start) || (state == CHECK && idx != 2'd3);
  assign timerDec = state == APPLY && timerVal != 4'd0;
  sweep_timer u_timer (
    .clk(clk), .rst_n(rst_n), .load(timerLoad), .dec(timerDec),
    .loadVal(RELOAD), .value(timerVal), .zero(timerZero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 2'd0;
      {drvA, drvB} <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_mask <= 4'd0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= APPLY;
          idx <= 2'd0;
          {drvA, drvB} <= 2'b00;
          busy <= 1'b1;
          pass <= 1'b0;
          fail_mask <= 4'd0;
          err_count <= 3'd0;
        end
        APPLY: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          {drvA, drvB} <= 2'b00;
          pass <= 1'b0;
        end else if (timerZero) state <= CHECK;
        CHECK: begin
          // the sample taken in this cycle is kept even when aborting
          fail_mask <= newMask;
          if (miss) err_count <= err_count + 3'd1;
          if (abort || idx == 2'd3) begin
            state <= abort ? IDLE : FINISH;
            busy <= 1'b0;
            done <= !abort;
            pass <= !abort && newMask == 4'd0;
            {drvA, drvB} <= 2'b00;
          end else begin
            state <= APPLY;
            idx <= idx + 2'd1;
            {drvA, drvB} <= idx + 2'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed and random sweeps on three configured sweepers
module tb_gate_sweep_ctrl;
  import gate_test_pkg::*;
  localparam logic [3:0] EXP [3] = '{TT_AND, TT_NOR, TT_XOR};
  localparam int SET [3] = '{1, 1, 3};
  logic clk = 1'b0, rst_n = 1'b0;
  logic start [3], abort [3], drvA [3], drvB [3], gateY [3], busy [3], done [3], pass [3];
  logic [3:0] failMask [3], gateTT [3];
  logic [2:0] errCount [3];
  int nAssert = 0, nFail = 0;
  always #5 clk = ~clk;
  always_comb
    for (int k = 0; k < 3; k++) gateY[k] = gateTT[k][{drvA[k], drvB[k]}];
  gate_sweep_ctrl #(.EXPECT(TT_AND), .SETTLE_CYCLES(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .drvA(drvA[0]), .drvB(drvB[0]),
    .gateY(gateY[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_mask(failMask[0]), .err_count(errCount[0]));
  gate_sweep_ctrl #(.EXPECT(TT_NOR), .SETTLE_CYCLES(1)) dutN (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .drvA(drvA[1]), .drvB(drvB[1]),
    .gateY(gateY[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_mask(failMask[1]), .err_count(errCount[1]));
  gate_sweep_ctrl #(.EXPECT(TT_XOR), .SETTLE_CYCLES(3)) dutX (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .drvA(drvA[2]), .drvB(drvB[2]),
    .gateY(gateY[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail_mask(failMask[2]), .err_count(errCount[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chkRest(input int u, input logic expPass, input logic [3:0] expMask);
    chk("idle_busy", 32'(busy[u]), 0);
    chk("idle_done", 32'(done[u]), 0);
    chk("idle_drv", 32'({drvA[u], drvB[u]}), 0);
    chk("idle_pass", 32'(pass[u]), 32'(expPass));
    chk("idle_mask", 32'(failMask[u]), 32'(expMask));
    chk("idle_err", 32'(errCount[u]), 32'($countones(expMask)));
  endtask
  // Model: vector v occupies cycles v*(s+1)..v*(s+1)+s after start; its last cycle is its sample point.
  task automatic sweep(input int u, input logic [3:0] tt, input int abortAt, input bit extraStart, input bit abortWithStart);
    int s = SET[u];
    int total = 4 * (s + 1);
    logic [3:0] recorded = 4'd0;
    logic [3:0] mask;
    gateTT[u] = tt;
    @(negedge clk);
    start[u] = 1'b1;
    abort[u] = abortWithStart;
    @(negedge clk);
    start[u] = 1'b0;
    abort[u] = 1'b0;
    for (int c = 0; c < total; c++) begin
      chk("busy", 32'(busy[u]), 1);
      chk("drv", 32'({drvA[u], drvB[u]}), 32'(c / (s + 1)));
      chk("done_early", 32'(done[u]), 0);
      if (c == 0) chk("cleared_mask", 32'(failMask[u]), 0);
      if ((c + 1) % (s + 1) == 0) recorded[c / (s + 1)] = 1'b1;
      if (c == abortAt) abort[u] = 1'b1;
      if (extraStart && c == 2) start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
      abort[u] = 1'b0;
      if (c == abortAt) break;
    end
    mask = (tt ^ EXP[u]) & recorded;
    if (abortAt >= 0 && abortAt < total) begin
      chkRest(u, 1'b0, mask);
    end else begin
      chk("done", 32'(done[u]), 1);
      chk("fin_busy", 32'(busy[u]), 0);
      chk("fin_drv", 32'({drvA[u], drvB[u]}), 0);
      chk("pass", 32'(pass[u]), 32'(mask == 4'd0));
      chk("mask", 32'(failMask[u]), 32'(mask));
      chk("err", 32'(errCount[u]), 32'($countones(mask)));
    end
    @(negedge clk);
    chkRest(u, abortAt < 0 && mask == 4'd0, mask);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      gateTT[k] = 4'd0;
    end
    #12;
    for (int k = 0; k < 3; k++) chkRest(k, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, TT_AND, -1, 1'b0, 1'b0);
    sweep(0, TT_NAND, -1, 1'b0, 1'b0);
    sweep(0, 4'b0000, -1, 1'b0, 1'b0);
    sweep(1, 4'b0000, -1, 1'b0, 1'b0);
    sweep(2, TT_XOR, -1, 1'b1, 1'b0);
    sweep(0, TT_AND, 4, 1'b0, 1'b0);
    sweep(0, TT_AND, -1, 1'b0, 1'b1);
    gateTT[0] = TT_NAND;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chkRest(0, 1'b0, 4'd0);
    chkRest(1, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, TT_AND, -1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      int u = int'($urandom_range(0, 2));
      int ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * (SET[u] + 1) - 1)) : -1;
      sweep(u, 4'($urandom_range(0, 15)), ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
